// File: rtl/uart_tx_fifo_if.sv
// Register-file side bundle for the UART transmitter: push strobe, overflow clear, serial line and status.
interface uart_tx_fifo_if #(
  parameter int unsigned FIFO_DEPTH = 16
) ();
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic          wr_en;
  logic [7:0]    wr_data;
  logic          ovf_clr;
  logic          tx;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;
  logic          busy;
  logic          ovf;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  tx, full, empty, level, busy, ovf
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output tx, full, empty, level, busy, ovf
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small write FIFO; status flags are registered for software polling.
module uart_tx_fifo #(
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_fifo_if.slave bus
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned LW = AW + 1;
  localparam logic [DIV_W-1:0] BAUD_RELOAD = DIV_W'(CLK_DIV - 1);
  localparam logic [LW-1:0]    DEPTH_L     = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]    count_q, count_d;
  logic             full_q, empty_q;
  logic             ovf_q, ovf_d;
  logic             push_c, pop_c;
  logic [7:0]       head_c;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             busy_q;

  // A full FIFO refuses the write even if a pop happens on the same edge.
  assign push_c = bus.wr_en && !full_q;
  assign head_c = mem_q[rd_ptr_q[AW-1:0]];

  // Byte count follows push/pop; simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    unique case ({push_c, pop_c})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // Sticky overflow: a dropped write beats a clear in the same cycle.
  always_comb begin
    ovf_d = ovf_q;
    if (bus.wr_en && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // Storage array; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q[AW-1:0]] <= bus.wr_data;
    end
  end

  // FIFO pointers, count and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      if (push_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_d;
      full_q  <= (count_d == DEPTH_L);
      empty_q <= (count_d == '0);
      ovf_q   <= ovf_d;
    end
  end

  // Frame sequencer: next state, baud/bit counters, shift register, line level and pop request.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_q) begin
          pop_c   = 1'b1;
          shift_d = head_c;
          baud_d  = BAUD_RELOAD;
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (baud_q == '0) begin
          state_d = DATA;
          bit_d   = 3'd0;
          baud_d  = BAUD_RELOAD;
          tx_d    = shift_q[0];
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d = BAUD_RELOAD;
          if (bit_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!empty_q) begin
            pop_c   = 1'b1;
            shift_d = head_c;
            baud_d  = BAUD_RELOAD;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - DIV_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  // Sequencer registers; the line idles high and is forced high by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
    end
  end

  assign bus.tx    = tx_q;
  assign bus.full  = full_q;
  assign bus.empty = empty_q;
  assign bus.level = count_q;
  assign bus.busy  = busy_q;
  assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, hand sequences, random traffic vs. a frame-timeline model.
module tb_uart_tx_fifo;
  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned FRAME   = 10 * CLK_DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(
    .CLK_DIV   (CLK_DIV),
    .DIV_W     (16),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of bytes plus a frame timeline ----------------
  logic [7:0] m_q[$];
  logic [7:0] done_q[$];
  logic [7:0] m_cur;
  bit         m_active;
  int         m_t;
  bit         m_ovf;
  bit         chk_en = 1'b0;

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / CLK_DIV;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  always begin
    logic s_rst, s_wr, s_clr, full_b, empty_b;
    logic [7:0] s_data;
    logic [7:0] exp_v, act_v;
    @(posedge clk);
    s_rst = rst; s_wr = bus.wr_en; s_clr = bus.ovf_clr; s_data = bus.wr_data;
    if (s_rst) begin
      m_q.delete(); m_active = 1'b0; m_t = 0; m_ovf = 1'b0;
    end else begin
      full_b  = (m_q.size() == DEPTH);
      empty_b = (m_q.size() == 0);
      if (m_active) begin
        if (m_t == FRAME - 1) begin
          done_q.push_back(m_cur);
          if (!empty_b) begin m_cur = m_q.pop_front(); m_t = 0; end
          else m_active = 1'b0;
        end else begin
          m_t++;
        end
      end else if (!empty_b) begin
        m_cur = m_q.pop_front(); m_active = 1'b1; m_t = 0;
      end
      if (s_wr && !full_b) m_q.push_back(s_data);
      if (s_wr && full_b) m_ovf = 1'b1;
      else if (s_clr) m_ovf = 1'b0;
    end
    #2;
    if (chk_en) begin
      exp_v = {model_tx(), m_active, m_q.size() == DEPTH, m_q.size() == 0, m_ovf, 3'(m_q.size())};
      act_v = {bus.tx, bus.busy, bus.full, bus.empty, bus.ovf, bus.level};
      check("model{tx,busy,full,empty,ovf,level}", int'(act_v), int'(exp_v));
    end
  end

  // ---------------- independent line decoder ----------------
  logic [7:0] rx_q[$];
  always begin
    logic r;
    bit in_f;
    int d_t;
    logic [7:0] d_b;
    @(posedge clk);
    r = rst;
    #2;
    if (r || rst) begin
      in_f = 1'b0;
    end else if (!in_f) begin
      if (bus.tx == 1'b0) begin in_f = 1'b1; d_t = 0; end
    end else begin
      d_t++;
      if (d_t >= 6 && d_t <= 34 && (d_t % 4) == 2) d_b[(d_t-6)/4] = bus.tx;
      if (d_t == 38) begin
        check("stop_bit", int'(bus.tx), 1);
        rx_q.push_back(d_b);
      end
      if (d_t == FRAME - 1) in_f = 1'b0;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.wr_en = 1'b1; bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while ((bus.busy || !bus.empty || n < 2) && n < bound) begin tick(); n++; end
    check("drain_in_time", int'(n < bound), 1);
  endtask

  typedef struct {
    logic       wr;
    logic [7:0] data;
    logic       clr;
    logic [2:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       busy;
    logic       tx;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int t;
    int next;
    int bound;
    logic [7:0] exp_b[$];

    tbl[0] = '{1'b1, 8'h11, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 8'h66, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[8] = '{1'b1, 8'h77, 1'b1, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

    bus.wr_en = 1'b0; bus.wr_data = 8'h00; bus.ovf_clr = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_tx", int'(bus.tx), 1);
    check("rst_full", int'(bus.full), 0);
    check("rst_empty", int'(bus.empty), 1);
    check("rst_level", int'(bus.level), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_ovf", int'(bus.ovf), 0);
    chk_en = 1'b1;
    rst = 1'b0;
    repeat (2) tick();

    // single byte 0x55, bit-centre sampling
    rx_q.delete();
    push(8'h55);
    check("s55_tx_before_pop", int'(bus.tx), 1);
    check("s55_level_after_push", int'(bus.level), 1);
    tick();
    check("s55_tx_fall", int'(bus.tx), 0);
    check("s55_busy_rise", int'(bus.busy), 1);
    check("s55_level_after_pop", int'(bus.level), 0);
    t = 0;
    for (int k = 0; k < 10; k++) begin
      while (t < 4 * k + 2) begin tick(); t++; end
      check($sformatf("s55_bit%0d", k), int'(bus.tx),
            (k == 0) ? 0 : (k == 9) ? 1 : int'((8'h55 >> (k - 1)) & 8'h01));
    end
    while (t < FRAME - 1) begin tick(); t++; end
    check("s55_busy_last_cycle", int'(bus.busy), 1);
    tick();
    check("s55_busy_drop", int'(bus.busy), 0);
    check("s55_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("s55_rx_byte", int'(rx_q[0]), 'h55);

    // back-to-back frames
    repeat (3) tick();
    rx_q.delete();
    bus.wr_en = 1'b1; bus.wr_data = 8'hA5; tick();
    bus.wr_data = 8'h3C; tick();
    bus.wr_en = 1'b0;
    check("b2b_first_start", int'(bus.tx), 0);
    t = 0;
    while (t < FRAME) begin tick(); t++; end
    check("b2b_second_start", int'(bus.tx), 0);
    check("b2b_busy_between", int'(bus.busy), 1);
    while (t < 2 * FRAME - 1) begin tick(); t++; end
    check("b2b_busy_end", int'(bus.busy), 1);
    tick();
    check("b2b_idle_after_80", int'(bus.busy), 0);
    check("b2b_rx_count", rx_q.size(), 2);
    if (rx_q.size() == 2) begin
      check("b2b_rx0", int'(rx_q[0]), 'hA5);
      check("b2b_rx1", int'(rx_q[1]), 'h3C);
    end

    // full / overflow vector table
    repeat (3) tick();
    rx_q.delete();
    for (int i = 0; i < 10; i++) begin
      bus.wr_en = tbl[i].wr; bus.wr_data = tbl[i].data; bus.ovf_clr = tbl[i].clr;
      tick();
      check($sformatf("tbl%0d{lvl,full,empty,ovf,busy,tx}", i),
            int'({bus.level, bus.full, bus.empty, bus.ovf, bus.busy, bus.tx}),
            int'({tbl[i].lvl, tbl[i].full, tbl[i].empty, tbl[i].ovf, tbl[i].busy, tbl[i].tx}));
    end
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
    drain(1000);
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    check("ovf_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check($sformatf("ovf_rx%0d", i), int'(rx_q[i]), int'(exp_b[i]));

    // reset asserted mid-frame
    bus.wr_en = 1'b1; bus.wr_data = 8'hF0; tick();
    bus.wr_data = 8'h12; tick();
    bus.wr_en = 1'b0;
    repeat (12) tick();
    #2;
    rst = 1'b1;
    #1;
    check("mrst_tx_async", int'(bus.tx), 1);
    check("mrst_busy_async", int'(bus.busy), 0);
    check("mrst_level_async", int'(bus.level), 0);
    tick();
    rst = 1'b0;
    tick();
    check("mrst_idle_after", int'(bus.busy), 0);
    check("mrst_empty_after", int'(bus.empty), 1);
    rx_q.delete();
    push(8'h00);
    drain(1000);
    check("mrst_rx_count", rx_q.size(), 1);
    if (rx_q.size() > 0) check("mrst_rx_byte", int'(rx_q[0]), 0);

    // simultaneous push/pop, then order across pointer wrap
    repeat (3) tick();
    rx_q.delete();
    for (int i = 0; i < 3; i++) begin
      bus.wr_en = 1'b1; bus.wr_data = 8'(i); tick();
    end
    bus.wr_en = 1'b0;
    check("pp_level_before", int'(bus.level), 2);
    repeat (FRAME - 2) tick();
    bus.wr_en = 1'b1; bus.wr_data = 8'd3; tick();
    bus.wr_en = 1'b0;
    check("pp_level_same", int'(bus.level), 2);
    check("pp_next_start", int'(bus.tx), 0);
    next = 4; bound = 0;
    while (next < 12 && bound < 2000) begin
      if (!bus.full) begin bus.wr_en = 1'b1; bus.wr_data = 8'(next); next++; end
      else bus.wr_en = 1'b0;
      tick(); bound++;
    end
    bus.wr_en = 1'b0;
    check("wrap_fed_in_time", int'(next == 12), 1);
    drain(2000);
    check("wrap_rx_count", rx_q.size(), 12);
    for (int i = 0; i < 12 && i < rx_q.size(); i++)
      check($sformatf("wrap_rx%0d", i), int'(rx_q[i]), i);

    // randomized traffic against the model
    rx_q.delete(); done_q.delete();
    for (int i = 0; i < 2500; i++) begin
      bus.wr_en   = ($urandom_range(0, 3) == 0);
      bus.wr_data = 8'($urandom);
      bus.ovf_clr = ($urandom_range(0, 15) == 0);
      tick();
    end
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
    drain(2000);
    check("rand_rx_count", rx_q.size(), done_q.size());
    for (int i = 0; i < rx_q.size() && i < done_q.size(); i++)
      check($sformatf("rand_rx%0d", i), int'(rx_q[i]), int'(done_q[i]));

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte-serial UART transmitter with a write FIFO, sitting directly downstream of the register file. Software writes a byte to the UART data register. The register file forwards that write as a one-cycle `wr_en`/`wr_data` strobe. The block queues the byte, serialises it as 8N1 at a fixed divider and drives the SoC `uart_tx` pin. Status outputs feed back into register-file read-only fields for software polling.

## Interface
Parameters:
- `CLK_DIV`, default 868: clock cycles per bit. Legal range 2..2^`DIV_W`-1.
- `DIV_W`, default 16: width of the baud counter.
- `FIFO_DEPTH`, default 16: number of queued bytes. Must be a power of two, ≥2.

Ports:
- `clk`  input  1: single clock. All logic is on the rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `wr_en`  input  1: one-cycle push strobe from the register file.
- `wr_data`  input  8: byte to queue; sampled when `wr_en`=1.
- `ovf_clr`  input  1: clears the sticky overflow flag.
- `tx`  output  1: serial line. Idle level is high.
- `full`  output  1: FIFO holds `FIFO_DEPTH` bytes.
- `empty`  output  1: FIFO holds 0 bytes.
- `level`  output  $clog2(`FIFO_DEPTH`)+1: current byte count.
- `busy`  output  1: a frame is in progress (FSM not IDLE).
- `ovf`  output  1: sticky flag, set when a write is dropped.

## Operation
- Reset values: `tx`=1, `full`=0, `empty`=1, `level`=0, `busy`=0, `ovf`=0. Reset also clears the FIFO pointers, the baud counter, the bit counter and the shift register.
- FIFO: circular buffer with read/write pointers one bit wider than the address, plus a registered count.
  - Push: when `wr_en`=1 and `full`=0.
  - `wr_en`=1 with `full`=1: the byte is dropped and `ovf` is set.
  - A pop in the same cycle does not make room for a write on a full FIFO; `full` is evaluated before the edge.
  - Push and pop in the same cycle: `level` is unchanged and both pointers advance.
  - Pointers wrap modulo `FIFO_DEPTH`.
- `ovf`:
  - Set by a dropped write; cleared by `ovf_clr`.
  - If a drop and `ovf_clr` occur in the same cycle, the set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `empty`=0, pop the head byte into the shift register, load the baud counter and go to START. `tx` goes low from the same edge.
  - START: hold `tx`=0 for `CLK_DIV` cycles, then go to DATA with bit index 0. `tx` = shift[0].
  - DATA: each bit lasts `CLK_DIV` cycles, LSB first. Shift right at each bit boundary. After bit 7 completes, go to STOP with `tx`=1.
  - STOP: hold `tx`=1 for `CLK_DIV` cycles. At the end:
    - if `empty`=0, pop and go directly to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE.
- Baud counter: loads `CLK_DIV`-1 at each bit start and decrements to 0. The bit boundary is the count==0 cycle.
- `tx` is driven from a flop. There is no combinational path from any input to `tx`.
- `busy` = (state != IDLE), registered.

## Timing
- Write at edge N into an empty FIFO with the FSM idle:
  - after edge N: `empty`=0, `level`=1;
  - at edge N+1: the pop happens, `tx` falls and `busy` rises, `level` returns to 0.
- Frame length is exactly 10×`CLK_DIV` cycles from the `tx` falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit begins on the edge right after the final stop cycle. A continuous stream has a period of 10×`CLK_DIV`.
- `full`, `empty` and `level` update on the edge after a push or pop. There is no look-ahead.
- Reset asserted mid-frame: `tx` goes high immediately (asynchronous), queued data is lost, and the FSM is in IDLE on release.
- Reset deassertion is synchronised upstream. The block needs no internal reset synchroniser.

## Test plan
Bench parameters: `CLK_DIV`=4, `FIFO_DEPTH`=4.
- Reset mid-frame: assert `rst` for 1 cycle while DATA is transmitting → `tx`=1 that same cycle, `level`=0, `busy`=0. A new write of 0x00 afterwards produces a clean frame: start, then eight 0 data bits, then stop.
- Single byte 0x55: push at edge N → `tx` falls at edge N+1. Over 40 cycles, sampling at bit centres, `tx` reads 0 (start), 1,0,1,0,1,0,1,0, then 1 (stop). `busy` drops after cycle 40.
- Back-to-back: push 0xA5 then 0x3C on consecutive cycles → two frames with no idle gap, total 80 cycles. Decoded bytes are 0xA5 then 0x3C.
- Full and overflow: write 6 bytes on consecutive cycles starting with an idle FSM. The first byte is popped one cycle after its push, so 5 bytes are stored and 1 is dropped. Result: `level` peaks at 4, `full`=1, `ovf`=1. Pulse `ovf_clr` → `ovf`=0. All 5 stored bytes are transmitted in order.
- Simultaneous push/pop: with `level`=2, push in the same cycle as the STOP→START pop → `level` stays 2. Order is preserved across pointer wrap over ≥3 FIFO laps (12 bytes, values 0..11).
